one_wire_rom_sequencer: RTL and testbench

ONE_WIRE_ROM_SEQUENCER -- requirements
Module: one_wire_rom_sequencer

---
 rtl/one_wire_rom_sequencer.sv | 176 +++++++++++++++++
 tb/tb_one_wire_rom_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_rom_sequencer.sv
// 1-Wire master sequencer: reset/presence, ROM command byte, handoff to an
// external ROM reader, then a bit-serial Dallas CRC8 check of the captured ID.
module one_wire_rom_sequencer #(
  parameter int         T_RST_LOW  = 480,
  parameter int         T_RST_REL  = 480,
  parameter int         T_PRES_SMP = 70,
  parameter int         T_SLOT     = 70,
  parameter int         T_W1_LOW   = 6,
  parameter int         T_W0_LOW   = 60,
  parameter logic [7:0] CMD        = 8'h33,
  parameter int         T_RD_TMO   = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bus,
  output logic        master_pull_low,
  output logic        en_read_rom,
  input  logic        done_reading_rom,
  input  logic [63:0] rom_mem,
  output logic        busy,
  output logic        done,
  output logic        err_presence,
  output logic        err_timeout,
  output logic        crc_ok,
  output logic [63:0] rom_id
);

  // state    | meaning
  // IDLE     | waiting for start
  // RST_LOW  | reset pulse, line held low
  // RST_REL  | line released, presence sampled once
  // CMD_SLOT | eight write slots carrying CMD, LSB first
  // READ     | external ROM reader enabled, bounded wait
  // CRC      | one CRC8 step per cycle over rom_id[55:0]
  // FIN      | one-cycle done pulse
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST_LOW  = 3'd1;
  localparam logic [2:0] S_RST_REL  = 3'd2;
  localparam logic [2:0] S_CMD_SLOT = 3'd3;
  localparam logic [2:0] S_READ     = 3'd4;
  localparam logic [2:0] S_CRC      = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  localparam int T_MAX_A = (T_RST_LOW > T_RST_REL) ? T_RST_LOW : T_RST_REL;
  localparam int T_MAX_B = (T_SLOT > T_RD_TMO) ? T_SLOT : T_RD_TMO;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  // Down-counter reload values and terminal/compare points
  localparam logic [CW-1:0] RST_LOW_LD = CW'(T_RST_LOW - 1);
  localparam logic [CW-1:0] RST_REL_LD = CW'(T_RST_REL - 1);
  localparam logic [CW-1:0] PRES_CNT   = CW'(T_RST_REL - 1 - T_PRES_SMP);
  localparam logic [CW-1:0] SLOT_LD    = CW'(T_SLOT - 1);
  localparam logic [CW-1:0] RD_LD      = CW'(T_RD_TMO - 1);
  localparam logic [CW-1:0] W1_THR     = CW'(T_SLOT - T_W1_LOW);
  localparam logic [CW-1:0] W0_THR     = CW'(T_SLOT - T_W0_LOW);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [5:0]    crc_idx;
  logic [7:0]    crc;
  logic          presence;

  logic          presence_now;
  logic [CW-1:0] low_thr;
  logic          crc_fb;
  logic [7:0]    crc_next;

  // presence_now also covers a sample point on the last release cycle
  assign presence_now = (cnt == PRES_CNT) ? ~bus : presence;
  assign low_thr      = CMD[bit_idx] ? W1_THR : W0_THR;
  assign crc_fb       = crc[0] ^ rom_id[crc_idx];
  assign crc_next     = {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);

  assign master_pull_low = (state == S_RST_LOW) ||
                           ((state == S_CMD_SLOT) && (cnt >= low_thr));
  assign en_read_rom     = (state == S_READ);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      crc_idx      <= '0;
      crc          <= '0;
      presence     <= 1'b0;
      err_presence <= 1'b0;
      err_timeout  <= 1'b0;
      crc_ok       <= 1'b0;
      rom_id       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_presence <= 1'b0;
            err_timeout  <= 1'b0;
            crc_ok       <= 1'b0;
            cnt          <= RST_LOW_LD;
            state        <= S_RST_LOW;
          end
        end
        S_RST_LOW: begin
          if (cnt == '0) begin
            cnt      <= RST_REL_LD;
            presence <= 1'b0;
            state    <= S_RST_REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RST_REL: begin
          presence <= presence_now;
          if (cnt == '0) begin
            if (presence_now) begin
              bit_idx <= '0;
              cnt     <= SLOT_LD;
              state   <= S_CMD_SLOT;
            end else begin
              err_presence <= 1'b1;
              state        <= S_FIN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CMD_SLOT: begin
          if (cnt == '0) begin
            if (bit_idx == 3'd7) begin
              cnt   <= RD_LD;
              state <= S_READ;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              cnt     <= SLOT_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_READ: begin
          if (done_reading_rom) begin
            rom_id  <= rom_mem;
            crc     <= '0;
            crc_idx <= '0;
            cnt     <= '0;
            state   <= S_CRC;
          end else if (cnt == '0) begin
            err_timeout <= 1'b1;
            state       <= S_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CRC: begin
          crc <= crc_next;
          if (crc_idx == 6'd55) begin
            crc_ok <= (crc_next == rom_id[63:56]);
            state  <= S_FIN;
          end else begin
            crc_idx <= crc_idx + 6'd1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_one_wire_rom_sequencer.sv
// Directed bench for one_wire_rom_sequencer: presence, command waveform,
// reader handoff, CRC pass/fail, reader timeout and mid-slot reset.
module tb_one_wire_rom_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        bus = 1'b1;
  logic        master_pull_low;
  logic        en_read_rom;
  logic        done_reading_rom = 1'b0;
  logic [63:0] rom_mem = '0;
  logic        busy;
  logic        done;
  logic        err_presence;
  logic        err_timeout;
  logic        crc_ok;
  logic [63:0] rom_id;

  one_wire_rom_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .bus              (bus),
    .master_pull_low  (master_pull_low),
    .en_read_rom      (en_read_rom),
    .done_reading_rom (done_reading_rom),
    .rom_mem          (rom_mem),
    .busy             (busy),
    .done             (done),
    .err_presence     (err_presence),
    .err_timeout      (err_timeout),
    .crc_ok           (crc_ok),
    .rom_id           (rom_id)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] ID_GOOD = 64'hA200000001B81C02;
  localparam logic [63:0] ID_BAD  = 64'hA300000001B81C02;
  localparam logic [63:0] ID_JUNK = 64'h5555AAAA1234ABCD;
  localparam int          BUDGET  = 12000;

  int vectors = 0;
  int miscompares = 0;

  int run_len[16];
  int run_start[16];
  int n_runs;
  int done_cnt;
  int done_cyc;
  int en_first;
  int rd_cyc;
  logic en_after_rd;
  logic en_at_done;
  logic busy_after;
  logic busy_first;
  logic [2:0] status_first;
  int exp_low[8] = '{6, 6, 60, 60, 6, 6, 60, 60};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rd_mode: 0 = reader answers after rd_delay enabled cycles, 1 = never,
  // 2 = done_reading_rom held high throughout. abort_at >= 0 resets mid-run.
  task automatic run_txn(input bit slave, input int rd_mode, input logic [63:0] id,
                         input int rd_delay, input int abort_at);
    int  cyc;
    int  rel;
    int  en_cnt;
    bit  pl_prev;
    n_runs = 0; done_cnt = 0; done_cyc = -1; en_first = -1; rd_cyc = -1;
    en_after_rd = 1'bx; en_at_done = 1'bx; busy_after = 1'bx;
    rel = -1; en_cnt = 0; pl_prev = 1'b0;
    rom_mem = id;
    done_reading_rom = (rd_mode == 2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy_first = busy;
    status_first = {err_presence, err_timeout, crc_ok};
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      if (master_pull_low && !pl_prev && n_runs < 16) run_start[n_runs] = cyc;
      if (!master_pull_low && pl_prev && n_runs < 16) begin
        run_len[n_runs] = cyc - run_start[n_runs];
        if (n_runs == 0) rel = cyc;
        n_runs++;
      end
      pl_prev = master_pull_low;
      bus = (master_pull_low || (slave && rel >= 0 && cyc >= rel + 20 && cyc < rel + 140)) ? 1'b0 : 1'b1;
      if (en_read_rom) begin
        if (en_first < 0) en_first = cyc;
        en_cnt++;
      end
      if (rd_mode != 2) done_reading_rom = 1'b0;
      if (rd_cyc >= 0 && cyc == rd_cyc + 1) en_after_rd = en_read_rom;
      if (rd_mode == 0 && en_read_rom && en_cnt == rd_delay && rd_cyc < 0) begin
        done_reading_rom = 1'b1;
        rd_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          en_at_done = en_read_rom;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (abort_at >= 0 && cyc == abort_at) begin
        chk("slot_low_before_rst", master_pull_low, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pull_low_same_cycle", master_pull_low, 1'b0);
        chk("rst_busy_same_cycle", busy, 1'b0);
        break;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
      @(negedge clk);
    end
    done_reading_rom = 1'b0;
    bus = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pull_low", master_pull_low, 1'b0);
    chk("rst_en_read_rom", en_read_rom, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_status", {err_presence, err_timeout, crc_ok}, 3'b000);
    chk("rst_rom_id", rom_id, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // No slave; a stray done_reading_rom outside READ must not load rom_id
    run_txn(1'b0, 2, ID_JUNK, 0, -1);
    chk("nos_busy_first", busy_first, 1'b1);
    chk("nos_low_runs", n_runs, 1);
    chk("nos_rst_low_len", run_len[0], 480);
    chk("nos_done_cyc", done_cyc, 960);
    chk("nos_done_cnt", done_cnt, 1);
    chk("nos_err_presence", err_presence, 1'b1);
    chk("nos_en_never", en_first, -1);
    chk("nos_rom_id_kept", rom_id, 64'h0);
    chk("nos_err_timeout", err_timeout, 1'b0);
    chk("nos_busy_after", busy_after, 1'b0);

    // Valid ID with presence pulse; full command waveform check
    run_txn(1'b1, 0, ID_GOOD, 5, -1);
    chk("ok_status_cleared", status_first, 3'b000);
    chk("ok_low_runs", n_runs, 9);
    chk("ok_rst_low_len", run_len[0], 480);
    chk("ok_slot0_start", run_start[1], 960);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ok_slot%0d_low", k), run_len[k + 1], exp_low[k]);
      if (k > 0) chk($sformatf("ok_slot%0d_period", k), run_start[k + 1] - run_start[k], 70);
    end
    chk("ok_en_first", en_first, 1520);
    chk("ok_en_drop", en_after_rd, 1'b0);
    chk("ok_done_cyc", done_cyc, 1524 + 57);
    chk("ok_done_cnt", done_cnt, 1);
    chk("ok_rom_id", rom_id, ID_GOOD);
    chk("ok_crc_ok", crc_ok, 1'b1);
    chk("ok_errors", {err_presence, err_timeout}, 2'b00);

    run_txn(1'b1, 0, 64'h0, 1, -1);
    chk("zero_crc_ok", crc_ok, 1'b1);
    chk("zero_rom_id", rom_id, 64'h0);

    run_txn(1'b1, 0, ID_BAD, 3, -1);
    chk("bad_crc_ok", crc_ok, 1'b0);
    chk("bad_rom_id", rom_id, ID_BAD);
    chk("bad_done_cnt", done_cnt, 1);

    // Reader never answers
    run_txn(1'b1, 1, ID_GOOD, 0, -1);
    chk("tmo_en_first", en_first, 1520);
    chk("tmo_done_cyc", done_cyc, 1520 + 8192);
    chk("tmo_en_at_done", en_at_done, 1'b0);
    chk("tmo_done_cnt", done_cnt, 1);
    chk("tmo_err_timeout", err_timeout, 1'b1);
    chk("tmo_rom_id_kept", rom_id, ID_BAD);
    chk("tmo_crc_ok", crc_ok, 1'b0);

    // Reset in the low phase of slot 2 (a written 0), then a clean rerun
    run_txn(1'b1, 0, ID_GOOD, 2, 960 + 140 + 10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_no_done", {done, busy, master_pull_low, en_read_rom}, 4'b0000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 0, ID_GOOD, 4, -1);
    chk("rerun_low_runs", n_runs, 9);
    chk("rerun_done_cyc", done_cyc, 1523 + 57);
    chk("rerun_done_cnt", done_cnt, 1);
    chk("rerun_crc_ok", crc_ok, 1'b1);
    chk("rerun_rom_id", rom_id, ID_GOOD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
